// File: rtl/esc_quad_pwm.sv
// Four-channel fixed-period ESC pulse generator with period-synchronous arming.
// Optional build macro ESC_SPD_CLAMP_EN clamps each speed to MAX_SPD before the width computation.
module esc_quad_pwm #(
  parameter int PERIOD    = 1_000_000,
  parameter int MIN_PULSE = 50_000,
  parameter int GAIN      = 24,
  parameter int ARM_PRDS  = 8,
  parameter int MAX_SPD   = 1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic [10:0] frnt_spd,
  input  logic [10:0] bck_spd,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        frnt_pwm,
  output logic        bck_pwm,
  output logic        lft_pwm,
  output logic        rght_pwm,
  output logic        armed,
  output logic        prd_strt
);

  localparam int N_CH  = 4;
  localparam int CNT_W = $clog2(PERIOD);
  localparam int ARM_W = $clog2(ARM_PRDS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] W_IDLE   = CNT_W'(MIN_PULSE);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_PRDS);

  // The widest pulse must still end before the next period starts.
  if (MIN_PULSE + 2047 * GAIN > PERIOD - 1 || MIN_PULSE < 0 || GAIN < 0 ||
      ARM_PRDS < 1 || MAX_SPD < 0 || MAX_SPD > 2047) begin : g_bad_cfg
    $error("esc_quad_pwm: illegal parameter set");
  end

  typedef enum logic [1:0] {
    ST_DISARMED,
    ST_ARMING,
    ST_ARMED
  } state_t;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             boundary;
  logic [10:0]      spd        [N_CH];
  logic             all_zero;
  state_t           state;
  logic [ARM_W-1:0] arm_cnt;
  logic [ARM_W-1:0] arm_cnt_inc;
  logic             load_armed;
  logic [CNT_W-1:0] width      [N_CH];
  logic [CNT_W-1:0] width_nxt  [N_CH];
  logic [N_CH-1:0]  pwm_q;

  function automatic logic [CNT_W-1:0] pulse_width(input logic [10:0] s);
    logic [10:0] s_eff;
`ifdef ESC_SPD_CLAMP_EN
    s_eff = (s > 11'(MAX_SPD)) ? 11'(MAX_SPD) : s;
`else
    s_eff = s;
`endif
    return CNT_W'(MIN_PULSE + int'(s_eff) * GAIN);
  endfunction

  assign spd[0] = frnt_spd;
  assign spd[1] = bck_spd;
  assign spd[2] = lft_spd;
  assign spd[3] = rght_spd;

  assign all_zero    = (frnt_spd | bck_spd | lft_spd | rght_spd) == 11'd0;
  assign boundary    = (cnt == CNT_LAST);
  assign cnt_nxt     = boundary ? '0 : cnt + 1'b1;
  assign arm_cnt_inc = arm_cnt + 1'b1;

  // True when the state after this boundary will be ARMED; the widths and the
  // armed flag both follow the post-boundary state.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    load_armed = 1'b0;
    case (state)
      ST_DISARMED: load_armed = arm && all_zero && (ARM_PRDS == 1);
      ST_ARMING:   load_armed = arm && all_zero && (arm_cnt_inc == ARM_LAST);
      ST_ARMED:    load_armed = arm;
      default:     load_armed = 1'b0;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      width_nxt[i] = width[i];
      if (boundary) width_nxt[i] = load_armed ? pulse_width(spd[i]) : W_IDLE;
    end
  end

  // Pulse flops look one cycle ahead so each output lines up with cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments; the small width array is reset like any other register.
      cnt      <= CNT_LAST;
      prd_strt <= 1'b0;
      pwm_q    <= '0;
      for (int i = 0; i < N_CH; i++) width[i] <= W_IDLE;
    end else begin
      cnt      <= cnt_nxt;
      prd_strt <= boundary;
      for (int i = 0; i < N_CH; i++) begin
        width[i] <= width_nxt[i];
        pwm_q[i] <= (cnt_nxt < width_nxt[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_DISARMED;
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (boundary) begin
      armed <= load_armed;
      case (state)
        ST_DISARMED: begin
          if (arm && all_zero) begin
            arm_cnt <= ARM_W'(1);
            state   <= load_armed ? ST_ARMED : ST_ARMING;
          end
        end
        ST_ARMING: begin
          if (!arm || !all_zero) begin
            state   <= ST_DISARMED;
            arm_cnt <= '0;
          end else begin
            arm_cnt <= arm_cnt_inc;
            if (load_armed) state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (!arm) begin
            state   <= ST_DISARMED;
            arm_cnt <= '0;
          end
        end
        default: begin
          state   <= ST_DISARMED;
          arm_cnt <= '0;
        end
      endcase
    end
  end

  assign frnt_pwm = pwm_q[0];
  assign bck_pwm  = pwm_q[1];
  assign lft_pwm  = pwm_q[2];
  assign rght_pwm = pwm_q[3];

endmodule

// File: tb/tb_esc_quad_pwm.sv
// Bench for esc_quad_pwm: period-level behavioural model checked every cycle plus literal pulse widths.
module tb_esc_quad_pwm;

  localparam int PERIOD    = 4096;
  localparam int MIN_PULSE = 1000;
  localparam int GAIN      = 1;
  localparam int ARM_PRDS  = 4;
  localparam int MAX_SPD   = 1800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arm = 1'b1;
  logic [10:0] frnt_spd = '0, bck_spd = '0, lft_spd = '0, rght_spd = '0;
  logic        frnt_pwm, bck_pwm, lft_pwm, rght_pwm, armed, prd_strt;

  int tests = 0;
  int fails = 0;
  bit go = 1'b0;

  esc_quad_pwm #(
    .PERIOD(PERIOD), .MIN_PULSE(MIN_PULSE), .GAIN(GAIN),
    .ARM_PRDS(ARM_PRDS), .MAX_SPD(MAX_SPD)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm),
    .frnt_spd(frnt_spd), .bck_spd(bck_spd), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .frnt_pwm(frnt_pwm), .bck_pwm(bck_pwm), .lft_pwm(lft_pwm), .rght_pwm(rght_pwm),
    .armed(armed), .prd_strt(prd_strt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: period index, cycle within period, run of qualifying boundaries, armed flag, widths.
  int mk, mprd, mrun;
  bit marmed;
  int mw [4];
  int ms [4];

  function automatic int eff_spd(input int s);
`ifdef ESC_SPD_CLAMP_EN
    return (s > MAX_SPD) ? MAX_SPD : s;
`else
    return s;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mk = PERIOD - 1; mprd = 0; mrun = 0; marmed = 1'b0;
      for (int i = 0; i < 4; i++) mw[i] = MIN_PULSE;
    end else begin
      if (mk == PERIOD - 1) begin
        ms[0] = frnt_spd; ms[1] = bck_spd; ms[2] = lft_spd; ms[3] = rght_spd;
        if (marmed) begin
          if (!arm) begin marmed = 1'b0; mrun = 0; end
        end else begin
          mrun = (arm && (ms[0] + ms[1] + ms[2] + ms[3] == 0)) ? mrun + 1 : 0;
          if (mrun >= ARM_PRDS) begin marmed = 1'b1; mrun = 0; end
        end
        for (int i = 0; i < 4; i++)
          mw[i] = marmed ? MIN_PULSE + eff_spd(ms[i]) * GAIN : MIN_PULSE;
        mprd++;
      end
      mk = (mk + 1) % PERIOD;
    end
  end

  always @(negedge clk) begin
    if (go)
      check("cycle {f,b,l,r,armed,prd_strt}",
            {26'd0, frnt_pwm, bck_pwm, lft_pwm, rght_pwm, armed, prd_strt},
            {26'd0, mk < mw[0], mk < mw[1], mk < mw[2], mk < mw[3], marmed, mk == 0});
  end

  // Measured high time of each channel over the most recently completed period.
  int hi [4];
  int done [4];
  always @(negedge clk) begin
    logic [3:0] p;
    p = {rght_pwm, lft_pwm, bck_pwm, frnt_pwm};
    for (int i = 0; i < 4; i++) begin
      if (mk == 0) begin done[i] = hi[i]; hi[i] = int'(p[i]); end
      else hi[i] += int'(p[i]);
    end
  end

  task automatic goto(input int p, input int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mprd == p && mk == c) && n < 3 * PERIOD);
    if (n >= 3 * PERIOD) begin
      tests++;
      fails++;
      $display("FAIL goto timeout: got period %0d cycle %0d expected period %0d cycle %0d", mprd, mk, p, c);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    go = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset in the middle of a pulse.
    goto(1, 500);
    check("frnt high mid-pulse", frnt_pwm, 1);
    #2 rst = 1'b1;
    #1 check("outputs low in reset", {frnt_pwm, bck_pwm, lft_pwm, rght_pwm, armed, prd_strt}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("prd_strt after release", prd_strt, 1);
    check("frnt pulse starts", frnt_pwm, 1);

    // Arm sequence from reset with zero speeds.
    for (int p = 1; p <= 3; p++) begin
      goto(p, 1);
      check($sformatf("armed after boundary %0d", p), armed, 0);
    end
    goto(4, 1);
    check("armed after boundary 4", armed, 1);
    goto(4, 10);
    frnt_spd = 11'd500; bck_spd = 11'd0; lft_spd = 11'd2047; rght_spd = 11'd1;

    goto(5, 1);
    check("armed zero-speed frnt width", done[0], 1000);
    check("armed zero-speed rght width", done[3], 1000);
    goto(5, 200);
    frnt_spd = 11'd1500;

    goto(6, 1);
    check("frnt width 500", done[0], 1500);
    check("bck width 0", done[1], 1000);
    check("lft width 2047", done[2], 3047);
    check("rght width 1", done[3], 1001);
    goto(6, 10);
    frnt_spd = 11'd2000;

    goto(7, 1);
    check("frnt width 1500", done[0], 2500);
    goto(7, 10);
    frnt_spd = 11'd500;

    goto(8, 1);
`ifdef ESC_SPD_CLAMP_EN
    check("frnt width 2000 clamped", done[0], 2800);
`else
    check("frnt width 2000 unclamped", done[0], 3000);
`endif
    goto(8, 300);
    arm = 1'b0;

    goto(9, 1);
    check("pulse completes after disarm", done[0], 1500);
    check("armed after disarm", armed, 0);
    goto(9, 10);
    frnt_spd = '0; bck_spd = '0; lft_spd = '0; rght_spd = '0;
    arm = 1'b1;

    goto(10, 1);
    check("disarmed frnt width", done[0], 1000);
    check("disarmed lft width", done[2], 1000);
    check("armed at boundary 10", armed, 0);

    // Abort while arming with two qualifying periods counted.
    goto(11, 10);
    lft_spd = 11'd5;
    goto(12, 1);
    check("armed after abort", armed, 0);
    goto(12, 10);
    lft_spd = 11'd0;
    for (int p = 13; p <= 15; p++) begin
      goto(p, 1);
      check($sformatf("re-arming boundary %0d", p), armed, 0);
    end
    goto(16, 1);
    check("re-armed at boundary 16", armed, 1);
    goto(16, 1100);
    check("frnt low after idle pulse", frnt_pwm, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
